// File: rtl/cdc_hs_tx.sv
// Four-phase req/ack transmitter: hands one WIDTH-bit word at a time to a remote clock domain.
// Define CDC_HS_TX_TIMEOUT_EN to add the sticky err output and its ack-wait cycle counter.
`timescale 1ns/1ps
module cdc_hs_tx #(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             req,
    output logic [WIDTH-1:0] tx_data,
    input  logic             ack_async,
`ifdef CDC_HS_TX_TIMEOUT_EN
    output logic             err,
`endif
    output logic             done
);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] WAIT_ACK_HI = 2'd1;
    localparam logic [1:0] WAIT_ACK_LO = 2'd2;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cdc_hs_tx: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0] state;
    logic       ack_q1;
    logic       ack_sync;

    // Only ack_q1 ever samples ack_async; everything else uses ack_sync.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q1   <= 1'b0;
            ack_sync <= 1'b0;
        end else begin
            ack_q1   <= ack_async;
            ack_sync <= ack_q1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            req     <= 1'b0;
            tx_data <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A leftover ack_sync=1 here is deliberately ignored.
                    if (s_valid) begin
                        tx_data <= s_data;
                        req     <= 1'b1;
                        state   <= WAIT_ACK_HI;
                    end
                end
                WAIT_ACK_HI: begin
                    if (ack_sync) begin
                        req   <= 1'b0;
                        state <= WAIT_ACK_LO;
                    end
                end
                WAIT_ACK_LO: begin
                    if (!ack_sync) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    req   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign s_ready = (state == IDLE);

`ifdef CDC_HS_TX_TIMEOUT_EN
    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;

    // Counts edges spent waiting on ack; err rises on the TIMEOUT_CYCLES-th one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (cnt >= CNT_MAX - 1'b1) err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Self-checking bench for cdc_hs_tx: directed vector table, hand sequences, and a
// randomized run against a cycle-level protocol model with a four-phase responder.
`timescale 1ns/1ps
module tb_cdc_hs_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         req;
    logic [W-1:0] tx_data;
    logic         ack_async;
    logic         done;
`ifdef CDC_HS_TX_TIMEOUT_EN
    logic         err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cdc_hs_tx #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .req       (req),
        .tx_data   (tx_data),
        .ack_async (ack_async),
`ifdef CDC_HS_TX_TIMEOUT_EN
        .err       (err),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         a;
        logic         e_req;
        logic         e_rdy;
        logic         e_done;
        logic [W-1:0] e_tx;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; s_data = '0; ack_async = 1'b0;
        #2;
        chk("rst_req", req, 0);
        chk("rst_ready", s_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_tx", tx_data, 0);
`ifdef CDC_HS_TX_TIMEOUT_EN
        chk("rst_err", err, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Protocol model: ack seen by the FSM at an edge is the ack driven two edges earlier.
    task automatic run_model(input int ncyc, input bit b2b);
        int           phase = 0;
        logic         m_req = 0, m_done = 0, h1 = 0, h2 = 0, seen, prev_req = 0;
        logic [W-1:0] m_tx = '0;
        logic [W-1:0] words[2];
        int           widx = 0, nrise = 0, ndone = 0, m_ndone = 0;
        words[0] = 8'h01; words[1] = 8'h02;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            if (b2b) begin
                s_valid   = (widx < 2);
                s_data    = words[widx % 2];
                ack_async = m_req;
            end else begin
                s_valid = ($urandom_range(0, 2) == 0);
                s_data  = W'($urandom);
                if (m_req && !ack_async && $urandom_range(0, 2) == 0) ack_async = 1'b1;
                else if (!m_req && ack_async && $urandom_range(0, 2) == 0) ack_async = 1'b0;
            end
            seen = h2; h2 = h1; h1 = ack_async;
            m_done = 1'b0;
            case (phase)
                0: if (s_valid) begin m_tx = s_data; m_req = 1'b1; phase = 1; widx++; end
                1: if (seen) begin m_req = 1'b0; phase = 2; end
                default: if (!seen) begin m_done = 1'b1; m_ndone++; phase = 0; end
            endcase
            tick();
            chk("mdl_req", req, m_req);
            chk("mdl_ready", s_ready, phase == 0);
            chk("mdl_done", done, m_done);
            chk("mdl_tx", tx_data, m_tx);
            if (b2b && req && !prev_req) begin
                if (nrise < 2) chk("b2b_word", tx_data, words[nrise]);
                nrise++;
            end
            if (done) ndone++;
            prev_req = req;
        end
        chk(b2b ? "b2b_done_count" : "rnd_done_count", ndone, m_ndone);
        if (b2b) chk("b2b_req_pulses", nrise, 2);
        s_valid = 1'b0; ack_async = 1'b0;
    endtask

    initial begin
        // Single transfer: accept at edge 0, ack raised before edge 5, dropped before edge 10;
        // s_data=0x3C offered while busy must be ignored. Entries 14..19: stale ack in IDLE.
        //          v  d      a  req rdy done tx
        tbl[0]  = '{1, 8'hA5, 0, 1,  0,  0,  8'hA5};
        tbl[1]  = '{1, 8'h3C, 0, 1,  0,  0,  8'hA5};
        tbl[2]  = '{1, 8'h3C, 0, 1,  0,  0,  8'hA5};
        tbl[3]  = '{1, 8'h3C, 0, 1,  0,  0,  8'hA5};
        tbl[4]  = '{1, 8'h3C, 0, 1,  0,  0,  8'hA5};
        tbl[5]  = '{0, 8'h00, 1, 1,  0,  0,  8'hA5};
        tbl[6]  = '{0, 8'h00, 1, 1,  0,  0,  8'hA5};
        tbl[7]  = '{0, 8'h00, 1, 0,  0,  0,  8'hA5};
        tbl[8]  = '{0, 8'h00, 1, 0,  0,  0,  8'hA5};
        tbl[9]  = '{0, 8'h00, 1, 0,  0,  0,  8'hA5};
        tbl[10] = '{0, 8'h00, 0, 0,  0,  0,  8'hA5};
        tbl[11] = '{0, 8'h00, 0, 0,  0,  0,  8'hA5};
        tbl[12] = '{0, 8'h00, 0, 0,  1,  1,  8'hA5};
        tbl[13] = '{0, 8'h00, 0, 0,  1,  0,  8'hA5};
        tbl[14] = '{0, 8'h00, 1, 0,  1,  0,  8'hA5};
        tbl[15] = '{0, 8'h00, 1, 0,  1,  0,  8'hA5};
        tbl[16] = '{0, 8'h00, 1, 0,  1,  0,  8'hA5};
        tbl[17] = '{0, 8'h00, 1, 0,  1,  0,  8'hA5};
        tbl[18] = '{0, 8'h00, 0, 0,  1,  0,  8'hA5};
        tbl[19] = '{0, 8'h00, 0, 0,  1,  0,  8'hA5};

        do_reset();
        chk("post_rst_ready", s_ready, 1);
        for (int i = 0; i < 20; i++) begin
            s_valid = tbl[i].v; s_data = tbl[i].d; ack_async = tbl[i].a;
            tick();
            chk($sformatf("tbl%0d_req", i), req, tbl[i].e_req);
            chk($sformatf("tbl%0d_ready", i), s_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
            chk($sformatf("tbl%0d_tx", i), tx_data, tbl[i].e_tx);
        end

        // Ack already high when the request goes out: advances on the very next edge.
        ack_async = 1'b1;
        repeat (3) tick();
        chk("early_ack_idle_req", req, 0);
        s_valid = 1'b1; s_data = 8'h5A;
        tick();
        chk("early_ack_req_hi", req, 1);
        chk("early_ack_tx", tx_data, 8'h5A);
        s_valid = 1'b0;
        tick();
        chk("early_ack_req_lo", req, 0);
        ack_async = 1'b0;
        repeat (2) tick();
        chk("early_ack_no_done", done, 0);
        tick();
        chk("early_ack_done", done, 1);
        chk("early_ack_ready", s_ready, 1);

        // Asynchronous reset between edges while req is high, then a stale ack.
        s_valid = 1'b1; s_data = 8'h77;
        tick();
        s_valid = 1'b0;
        tick();
        chk("arst_pre_req", req, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_req", req, 0);
        chk("arst_ready", s_ready, 1);
        chk("arst_tx", tx_data, 0);
        ack_async = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_stale_req", req, 0);
            chk("arst_stale_ready", s_ready, 1);
        end
        ack_async = 1'b0;
        repeat (3) tick();

        run_model(20, 1'b1);
        run_model(2000, 1'b0);

`ifdef CDC_HS_TX_TIMEOUT_EN
        do_reset();
        s_valid = 1'b1; s_data = 8'hC3;
        tick();
        s_valid = 1'b0;
        chk("to_req_rise", req, 1);
        repeat (15) tick();
        chk("to_err_early", err, 0);
        tick();
        chk("to_err_set", err, 1);
        chk("to_req_held", req, 1);
        ack_async = 1'b1;
        repeat (2) tick();
        chk("to_req_wait", req, 1);
        tick();
        chk("to_req_fall", req, 0);
        ack_async = 1'b0;
        repeat (3) tick();
        chk("to_done", done, 1);
        chk("to_err_sticky", err, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_hs_tx.md
CDC_HS_TX -- requirements
Module: cdc_hs_tx

Interface
REQ-001 Parameter WIDTH, default 8: payload width in bits.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: cycles to wait for ack before flagging an error; used only when the timeout feature is compiled in.
REQ-003 clk  input  1  single source-domain clock; all state is updated on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 s_valid  input  1  upstream word is offered.
REQ-006 s_ready  output  1  block can accept a word; high only in IDLE.
REQ-007 s_data  input  WIDTH  upstream payload.
REQ-008 req  output  1  registered four-phase request to the remote domain.
REQ-009 tx_data  output  WIDTH  registered payload; held stable from req rise until req fall.
REQ-010 ack_async  input  1  remote-domain acknowledge; asynchronous to clk.
REQ-011 done  output  1  one-cycle pulse when a transfer completes.
REQ-012 err  output  1  sticky timeout flag; present only with CDC_HS_TX_TIMEOUT_EN.

Function
REQ-013 ack_async SHALL pass through an internal two-flop synchronizer (ack_q1 -> ack_sync) before any use; no other logic samples ack_async.
REQ-014 The FSM SHALL have three states: IDLE, WAIT_ACK_HI and WAIT_ACK_LO.
REQ-015 IDLE: s_ready=1; on s_valid at edge N, capture s_data into tx_data, set req=1 and enter WAIT_ACK_HI, with all of this visible after edge N.
REQ-016 WAIT_ACK_HI: s_ready=0, req=1 and tx_data frozen; on the edge that samples ack_sync=1, clear req and enter WAIT_ACK_LO.
REQ-017 WAIT_ACK_LO: s_ready=0 and req=0; on the edge that samples ack_sync=0, pulse done for exactly one cycle and enter IDLE.
REQ-018 Latency: if ack_async rises before edge K, req falls after edge K+2; the same 2-cycle synchronizer delay applies to the ack fall.
REQ-019 Minimum transfer is 1 + 3 + 3 = 7 cycles from accept to the next s_ready=1.
REQ-020 s_valid and s_data SHALL be ignored outside IDLE; no buffering and no overwrite of tx_data.
REQ-021 Back-to-back: done and s_ready are high in the same cycle, so a new word may be accepted on the edge that ends the done cycle.
REQ-022 A stale ack_sync=1 seen in IDLE SHALL be ignored, and no state change occurs.
REQ-023 An ack that is already high when entering WAIT_ACK_HI is legal and SHALL advance on the next edge.
REQ-024 All outputs SHALL be registered or decoded from the state register only; s_ready SHALL NOT depend combinationally on s_valid.

Reset
REQ-025 Assertion of rst SHALL immediately force state=IDLE, req=0, tx_data=0, ack_q1=0, ack_sync=0, done=0 and err=0, independent of clk.
REQ-026 Reset mid-transfer SHALL drop req without completing the handshake; the remote side must tolerate the abandoned request.
REQ-027 After rst deasserts, s_ready=1 from the first cycle.

Configuration
REQ-028 Macro CDC_HS_TX_TIMEOUT_EN defined: a counter SHALL run in WAIT_ACK_HI and WAIT_ACK_LO and clear in IDLE; on reaching TIMEOUT_CYCLES, err is set and stays set until rst.
REQ-029 The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates.
REQ-030 A timeout SHALL NOT alter the FSM, req or done.
REQ-031 Macro undefined: no err port, no counter logic, and behaviour is otherwise identical.

Verification
REQ-032 Single transfer: s_valid=1 with s_data=0xA5 in IDLE -> next cycle req=1, tx_data=0xA5, s_ready=0; ack_async raised at cycle 5 -> req=0 at cycle 7; ack dropped at cycle 10 -> done=1 at cycle 12, s_ready=1.
REQ-033 Hold: while req=1, drive s_valid=1 with s_data=0x3C -> tx_data stays 0xA5 and no second accept.
REQ-034 Back-to-back: words 0x01 and 0x02 with a responder that acks 1 cycle after req -> both delivered in order, each req pulse carries the correct tx_data, and done pulses twice.
REQ-035 Async reset: assert rst between clk edges while req=1 -> req=0 and state=IDLE immediately; after release, s_ready=1 and a stale ack_async=1 causes no req change.
REQ-036 Timeout (macro defined, TIMEOUT_CYCLES=16): ack never asserted -> err=1 sixteen cycles after req rises, req still 1; a later ack completes the transfer normally and err stays 1.
